// File: rtl/sync_down_timer_if.sv
// sync_down_timer_if: control and status bundle between a timer master and the sync_down_timer.
interface sync_down_timer_if #(parameter int WIDTH = 4);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    modport master (output en, load, load_val, start, stop, auto_reload, input count, tc, busy);
    modport slave  (input en, load, load_val, start, stop, auto_reload, output count, tc, busy);
endinterface

// File: rtl/sync_down_timer.sv
// sync_down_timer: loadable down-counter with one-shot/periodic modes and a registered terminal-count pulse.
module sync_down_timer #(parameter int WIDTH = 4) (
    input logic               clk,
    input logic               rst_n,
    sync_down_timer_if.slave  bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_period <= '0;
            r_count  <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (bus.load) begin
                r_period <= bus.load_val;
                r_count  <= bus.load_val;
                r_state  <= S_IDLE;
            end else if (bus.stop) begin
                r_state <= S_IDLE;
            end else if (r_state == S_IDLE) begin
                if (bus.start) begin
                    if (r_period != '0) begin
                        r_count <= r_period;
                        r_state <= S_RUN;
                    end else begin
                        r_count <= '0;
                        r_tc    <= 1'b1;
                    end
                end
            end else if (bus.en) begin
                // RUN never holds zero: it is entered only with a nonzero period
                if (r_count > WIDTH'(1)) begin
                    r_count <= r_count - WIDTH'(1);
                end else begin
                    r_tc <= 1'b1;
                    if (bus.auto_reload) begin
                        r_count <= r_period;
                    end else begin
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end
                end
            end
        end
    end
    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.busy  = (r_state == S_RUN);
endmodule

// File: tb/tb_sync_down_timer.sv
// tb_sync_down_timer: directed spec scenarios plus random traffic against a behavioural timer model.
module tb_sync_down_timer;
    localparam int W = 4;
    logic clk;
    logic rst_n;
    int checks;
    int failures;
    int m_period, m_count, m_run, m_tc;
    sync_down_timer_if #(.WIDTH(W)) b ();
    sync_down_timer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_period = 0;
        m_count  = 0;
        m_run    = 0;
        m_tc     = 0;
    endtask
    // Behavioural model: one clock of the timer, described by its control rules.
    task automatic model_step(input int ld, input int lv, input int st, input int sp, input int e, input int ar);
        m_tc = 0;
        if (ld != 0) begin
            m_period = lv;
            m_count  = lv;
            m_run    = 0;
        end else if (sp != 0) begin
            m_run = 0;
        end else if (m_run == 0) begin
            if (st != 0) begin
                if (m_period == 0) m_tc = 1;
                else begin
                    m_count = m_period;
                    m_run   = 1;
                end
            end
        end else if (e != 0) begin
            if (m_count > 1) m_count = m_count - 1;
            else begin
                m_tc    = 1;
                m_count = (ar != 0) ? m_period : 0;
                m_run   = (ar != 0) ? 1 : 0;
            end
        end
    endtask
    task automatic step(input string tag, input int ld, input int lv, input int st, input int sp, input int e, input int ar);
        b.load        = ld[0];
        b.load_val    = lv[W-1:0];
        b.start       = st[0];
        b.stop        = sp[0];
        b.en          = e[0];
        b.auto_reload = ar[0];
        @(posedge clk);
        #1;
        model_step(ld, lv, st, sp, e, ar);
        chk({tag, "_count"}, int'(b.count), m_count);
        chk({tag, "_tc"}, int'(b.tc), m_tc);
        chk({tag, "_busy"}, int'(b.busy), m_run);
    endtask
    initial begin
        int tc_gap;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        b.load = 1'b0; b.load_val = '0; b.start = 1'b0; b.stop = 1'b0; b.en = 1'b0; b.auto_reload = 1'b0;
        model_reset();
        #2;
        chk("rst_count", int'(b.count), 0);
        chk("rst_tc", int'(b.tc), 0);
        chk("rst_busy", int'(b.busy), 0);
        #6 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // start with no prior load behaves as a zero period
        step("nolоad_start", 0, 0, 1, 0, 1, 0);
        chk("nolоad_tc", int'(b.tc), 1);
        step("nolоad_after", 0, 0, 0, 0, 1, 0);
        // one-shot from 3
        step("os_load", 1, 3, 0, 0, 0, 0);
        step("os_start", 0, 0, 1, 0, 1, 0);
        chk("os_c3", int'(b.count), 3);
        step("os_d2", 0, 0, 0, 0, 1, 0);
        step("os_d1", 0, 0, 0, 0, 1, 0);
        chk("os_c1", int'(b.count), 1);
        step("os_d0", 0, 0, 0, 0, 1, 0);
        chk("os_c0", int'(b.count), 0);
        chk("os_tc", int'(b.tc), 1);
        chk("os_busy", int'(b.busy), 0);
        step("os_post", 0, 0, 0, 0, 1, 0);
        chk("os_tc_off", int'(b.tc), 0);
        // periodic with period 2: tc spacing must equal the period
        step("per_load", 1, 2, 0, 0, 0, 1);
        step("per_start", 0, 0, 1, 0, 1, 1);
        tc_gap = -1;
        for (int i = 0; i < 8; i++) begin
            step("per_run", 0, 0, 0, 0, 1, 1);
            chk("per_busy", int'(b.busy), 1);
            chk("per_cnt", int'(b.count), (i % 2 == 0) ? 1 : 2);
            chk("per_tc", int'(b.tc), i % 2);
        end
        // enable gating from 4
        step("en_load", 1, 4, 0, 0, 0, 0);
        step("en_start", 0, 0, 1, 0, 0, 0);
        chk("en_c4", int'(b.count), 4);
        for (int i = 0; i < 4; i++) begin
            step("en_gate", 0, 0, 0, 0, (i % 2 == 0) ? 1 : 0, 0);
            chk("en_cnt", int'(b.count), (i < 2) ? 3 : 2);
            chk("en_tc", int'(b.tc), 0);
        end
        // priority: load beats stop and start while running at 5
        step("pri_load", 1, 7, 0, 0, 0, 0);
        step("pri_start", 0, 0, 1, 0, 1, 0);
        step("pri_d6", 0, 0, 0, 0, 1, 0);
        step("pri_d5", 0, 0, 0, 0, 1, 0);
        chk("pri_c5", int'(b.count), 5);
        step("pri_all", 1, 9, 1, 1, 1, 0);
        chk("pri_c9", int'(b.count), 9);
        chk("pri_busy", int'(b.busy), 0);
        chk("pri_tc", int'(b.tc), 0);
        // stop holds count; start in RUN ignored
        step("stp_start", 0, 0, 1, 0, 1, 0);
        step("stp_restart", 0, 0, 1, 0, 1, 0);
        chk("stp_c8", int'(b.count), 8);
        step("stp_stop", 0, 0, 0, 1, 1, 0);
        chk("stp_hold", int'(b.count), 8);
        chk("stp_busy", int'(b.busy), 0);
        step("stp_idle", 0, 0, 0, 0, 1, 0);
        chk("stp_nodec", int'(b.count), 8);
        // zero period
        step("zp_load", 1, 0, 0, 0, 0, 0);
        step("zp_start", 0, 0, 1, 0, 1, 0);
        chk("zp_tc", int'(b.tc), 1);
        chk("zp_busy", int'(b.busy), 0);
        chk("zp_cnt", int'(b.count), 0);
        step("zp_after", 0, 0, 0, 0, 1, 0);
        // asynchronous reset mid-countdown at 6
        step("ar_load", 1, 7, 0, 0, 0, 0);
        step("ar_start", 0, 0, 1, 0, 1, 0);
        step("ar_d6", 0, 0, 0, 0, 1, 0);
        chk("ar_c6", int'(b.count), 6);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count", int'(b.count), 0);
        chk("ar_busy", int'(b.busy), 0);
        chk("ar_tc", int'(b.tc), 0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #3;
        for (int i = 0; i < 3; i++) begin
            step("ar_post", 0, 0, 0, 0, 1, 0);
            chk("ar_no_tc", int'(b.tc), 0);
        end
        // random traffic
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 ($urandom_range(0, 9) == 0) ? 1 : 0,
                 int'($urandom_range(0, (1 << W) - 1)),
                 ($urandom_range(0, 4) == 0) ? 1 : 0,
                 ($urandom_range(0, 11) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, 1)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_down_timer.md
SYNC_DOWN_TIMER -- requirements
Module: sync_down_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter and reload-value width in bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  count enable; the counter decrements only on cycles with en=1.
REQ-005 load  input  1  captures load_val into the period register and the counter.
REQ-006 load_val  input  WIDTH  reload value.
REQ-007 start  input  1  begins a countdown from the period register.
REQ-008 stop  input  1  aborts a countdown; the counter holds its value.
REQ-009 auto_reload  input  1  selects periodic mode (1) or one-shot mode (0); sampled on the terminal cycle.
REQ-010 count  output  WIDTH  current counter value, registered.
REQ-011 tc  output  1  terminal-count pulse, registered, exactly one cycle wide.
REQ-012 busy  output  1  high exactly while the FSM is in RUN.

Function
REQ-013 The FSM SHALL have two states, IDLE and RUN; busy SHALL equal (state==RUN).
REQ-014 Control priority SHALL be load > stop > start, evaluated every cycle regardless of en.
REQ-015 load=1 SHALL set period<=load_val, count<=load_val and state<=IDLE, and SHALL clear tc, in any state; it aborts an active countdown.
REQ-016 stop=1 without load SHALL set state<=IDLE and hold count; in IDLE it SHALL have no effect.
REQ-017 start=1 in IDLE with period!=0 SHALL set count<=period and state<=RUN, independent of en.
REQ-018 start=1 in IDLE with period==0 SHALL assert tc for the next cycle and keep state IDLE with count=0.
REQ-019 start=1 in RUN SHALL be ignored.
REQ-020 In RUN with en=1 and count>1, count SHALL decrement by 1 with no other change.
REQ-021 In RUN with en=1 and count==1 (terminal cycle), tc SHALL be 1 on the following cycle.
REQ-022 On the terminal cycle with auto_reload=1, the block SHALL set count<=period and stay in RUN; the tc period is period en-cycles.
REQ-023 On the terminal cycle with auto_reload=0, the block SHALL set count<=0 and state<=IDLE.
REQ-024 In RUN with en=0, count, state and period SHALL hold and tc SHALL be 0.
REQ-025 tc SHALL be 0 on every cycle not required to be 1 by REQ-018 or REQ-021.
REQ-026 count SHALL never wrap below 0; no decrement SHALL occur in IDLE.
REQ-027 count, busy and tc SHALL be fully synchronous registered outputs with no ripple or glitch path from any input.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, count=0, period=0, tc=0 and busy=0, without waiting for a clock edge.
REQ-029 After rst_n deasserts, the first active edge SHALL evaluate inputs normally; a start with no prior load SHALL follow REQ-018.
REQ-030 Reset asserted mid-countdown SHALL abort the countdown with no tc pulse.

Verification
REQ-031 One-shot: load_val=3, load, then start, en=1, auto_reload=0 -> count 3,2,1,0; tc high for one cycle while count=0; busy low from that cycle on.
REQ-032 Periodic: load_val=2, auto_reload=1, start, en=1 for 8 cycles -> count 2,1,2,1,...; tc pulses every 2 cycles; busy stays 1.
REQ-033 Enable gating: load_val=4, start, en toggling 1,0,1,0 -> count 4,3,3,2,2; tc=0 throughout.
REQ-034 Priority: in RUN at count=5, drive load=1 (load_val=9), stop=1 and start=1 together -> count=9, busy=0, tc=0 next cycle.
REQ-035 Zero period: load_val=0, load, start -> one-cycle tc pulse, busy stays 0, count stays 0.
REQ-036 Async reset: assert rst_n=0 between clock edges at count=6 in RUN -> count=0, busy=0, tc=0 immediately, with no tc pulse after release.
